// File: rtl/merge3_sel_if.sv
// Handshake bundle for merge3_sel: one control channel, three data inputs, one data output.
// master = environment side, slave = the merge stage.
interface merge3_sel_if #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned CWIDTH = 2
);
    logic [CWIDTH-1:0] ctrl_data;
    logic              ctrl_valid;
    logic              ctrl_ready;

    logic [WIDTH-1:0]  in0_data;
    logic              in0_valid;
    logic              in0_ready;
    logic [WIDTH-1:0]  in1_data;
    logic              in1_valid;
    logic              in1_ready;
    logic [WIDTH-1:0]  in2_data;
    logic              in2_valid;
    logic              in2_ready;

    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output ctrl_data, ctrl_valid,
        output in0_data, in0_valid, in1_data, in1_valid, in2_data, in2_valid,
        output out_ready,
        input  ctrl_ready, in0_ready, in1_ready, in2_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  ctrl_data, ctrl_valid,
        input  in0_data, in0_valid, in1_data, in1_valid, in2_data, in2_valid,
        input  out_ready,
        output ctrl_ready, in0_ready, in1_ready, in2_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/merge3_sel.sv
// Controlled three-way merge: one select token picks which input supplies the next output token.
// All handshake outputs are registered, so no ready depends on any valid combinationally.
module merge3_sel #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned CWIDTH = 2
) (
    input logic        CLK,
    input logic        _RESET,
    merge3_sel_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWaitData, StSend} state_e;

    state_e            state_q, state_d;
    logic [CWIDTH-1:0] sel_q, sel_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              ctrl_ready_q, ctrl_ready_d;
    logic [2:0]        in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [2:0]        in_valid;
    logic [WIDTH-1:0]  sel_data;
    logic              ctrl_xfer;
    logic              ctrl_legal;

    assign in_valid   = {bus.in2_valid, bus.in1_valid, bus.in0_valid};
    assign ctrl_xfer  = bus.ctrl_valid && ctrl_ready_q;
    assign ctrl_legal = 32'(bus.ctrl_data) < 32'd3;

    always_comb begin
        sel_data = bus.in2_data;
        case (sel_q)
            CWIDTH'(0): sel_data = bus.in0_data;
            CWIDTH'(1): sel_data = bus.in1_data;
            default:    sel_data = bus.in2_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (ctrl_xfer) begin
                    sel_d = bus.ctrl_data;
                    // Select value 3 is consumed and dropped without touching any input.
                    if (ctrl_legal) begin
                        state_d = StWaitData;
                    end
                end
            end
            StWaitData: begin
                if (|(in_valid & in_ready_q)) begin
                    data_d  = sel_data;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Readies/valid are precomputed from the next state so they appear as flops.
    always_comb begin
        ctrl_ready_d = (state_d == StIdle);
        out_valid_d  = (state_d == StSend);
        in_ready_d   = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            in_ready_d[k] = (state_d == StWaitData) && (sel_d == CWIDTH'(k));
        end
    end

    always_ff @(posedge CLK) begin
        if (_RESET) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            data_q       <= '0;
            ctrl_ready_q <= 1'b0;
            in_ready_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            ctrl_ready_q <= ctrl_ready_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.ctrl_ready = ctrl_ready_q;
    assign bus.in0_ready  = in_ready_q[0];
    assign bus.in1_ready  = in_ready_q[1];
    assign bus.in2_ready  = in_ready_q[2];
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = data_q;
endmodule

// File: tb/tb_merge3_sel.sv
// Bench for merge3_sel: random and directed streams checked against a token-level merge model.
module tb_merge3_sel;
    localparam int unsigned WIDTH  = 11;
    localparam int unsigned CWIDTH = 2;
    localparam int          MAX_CYC = 2000;

    logic CLK    = 1'b0;
    logic _RESET = 1'b1;
    always #5 CLK = ~CLK;

    merge3_sel_if #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) bus ();

    merge3_sel #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) dut (
        .CLK    (CLK),
        ._RESET (_RESET),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int ctrl_list[$];
    logic [WIDTH-1:0] strm [3][$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic in_rdy(input int k);
        case (k)
            0:       return bus.in0_ready;
            1:       return bus.in1_ready;
            default: return bus.in2_ready;
        endcase
    endfunction

    function automatic logic excl_ok();
        int s;
        s = int'(bus.ctrl_ready) + int'(bus.in0_ready) + int'(bus.in1_ready)
            + int'(bus.in2_ready) + int'(bus.out_valid);
        return s <= 1;
    endfunction

    task automatic drive_in(input int k, input logic v, input logic [WIDTH-1:0] d);
        case (k)
            0:       begin bus.in0_valid = v; bus.in0_data = d; end
            1:       begin bus.in1_valid = v; bus.in1_data = d; end
            default: begin bus.in2_valid = v; bus.in2_data = d; end
        endcase
    endtask

    task automatic idle_bus();
        bus.ctrl_valid = 1'b0;
        bus.in0_valid  = 1'b0;
        bus.in1_valid  = 1'b0;
        bus.in2_valid  = 1'b0;
        bus.out_ready  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ctrl_ready"}, bus.ctrl_ready, 0);
        check_eq({tag, "_in_ready"}, {bus.in2_ready, bus.in1_ready, bus.in0_ready}, 0);
        check_eq({tag, "_out_valid"}, bus.out_valid, 0);
        check_eq({tag, "_out_data"}, bus.out_data, 0);
    endtask

    task automatic fill_inc(input int len);
        for (int k = 0; k < 3; k++) begin
            strm[k].delete();
            for (int i = 1; i <= len; i++) strm[k].push_back(WIDTH'(i));
        end
    endtask

    task automatic fill_rand(input int len);
        for (int k = 0; k < 3; k++) begin
            strm[k].delete();
            for (int i = 0; i < len; i++) strm[k].push_back(WIDTH'($urandom));
        end
    endtask

    // Expected output is simply: for each select token < 3, the next token of that stream.
    task automatic run_seq(input string tag, input int vpct, input int rpct, input bit chk_rate);
        logic [WIDTH-1:0] exp_q[$];
        int used[3];
        int iptr[3];
        bit iv[3];
        int cptr = 0, optr = 0, cyc = 0;
        int last_out = -1, first_ctrl = -1, first_ov = -1;
        bit cv = 1'b0, hold = 1'b0;
        logic [WIDTH-1:0] hold_data = '0;
        used = '{0, 0, 0};
        iptr = '{0, 0, 0};
        iv   = '{0, 0, 0};
        foreach (ctrl_list[i]) begin
            if (ctrl_list[i] < 3) begin
                exp_q.push_back(strm[ctrl_list[i]][used[ctrl_list[i]]]);
                used[ctrl_list[i]]++;
            end
        end

        while ((cptr < ctrl_list.size() || optr < exp_q.size()) && cyc < MAX_CYC) begin
            @(negedge CLK);
            cyc++;
            if (hold) begin
                check_eq({tag, "_hold_valid"}, bus.out_valid, 1);
                check_eq({tag, "_hold_data"}, bus.out_data, hold_data);
            end
            check_eq({tag, "_excl"}, excl_ok(), 1);
            if (bus.out_valid && first_ov < 0) first_ov = cyc;

            if (!cv && cptr < ctrl_list.size() && $urandom_range(99) < vpct) cv = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (!iv[k] && iptr[k] < strm[k].size() && $urandom_range(99) < vpct) iv[k] = 1'b1;
            end
            bus.ctrl_valid = cv;
            if (cv) bus.ctrl_data = CWIDTH'(ctrl_list[cptr]);
            for (int k = 0; k < 3; k++) begin
                if (iv[k]) drive_in(k, 1'b1, strm[k][iptr[k]]);
                else       drive_in(k, 1'b0, '0);
            end
            bus.out_ready = ($urandom_range(99) < rpct);

            // Transfers that the coming rising edge will perform.
            if (cv && bus.ctrl_ready) begin
                cptr++;
                cv = 1'b0;
                if (first_ctrl < 0) first_ctrl = cyc;
            end
            for (int k = 0; k < 3; k++) begin
                if (iv[k] && in_rdy(k)) begin
                    iptr[k]++;
                    iv[k] = 1'b0;
                end
            end
            hold      = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (optr < exp_q.size()) check_eq({tag, "_out"}, bus.out_data, exp_q[optr]);
                else                     check_eq({tag, "_extra_out"}, optr, exp_q.size());
                if (chk_rate && last_out >= 0) check_eq({tag, "_period"}, cyc - last_out, 3);
                last_out = cyc;
                optr++;
            end
        end

        check_eq({tag, "_in_time"}, cyc < MAX_CYC, 1);
        check_eq({tag, "_n_out"}, optr, exp_q.size());
        for (int k = 0; k < 3; k++) check_eq({tag, "_consumed"}, iptr[k], used[k]);
        if (chk_rate) check_eq({tag, "_latency"}, first_ov - first_ctrl, 2);
        bus.ctrl_valid = 1'b0;
        for (int k = 0; k < 3; k++) drive_in(k, 1'b0, '0);
        repeat (3) @(negedge CLK);
        check_eq({tag, "_quiet"}, bus.out_valid, 0);
        check_eq({tag, "_idle_ready"}, bus.ctrl_ready, 1);
    endtask

    task automatic backpressure();
        bit cx, ix, got;
        got = 1'b0;
        bus.out_ready  = 1'b0;
        bus.ctrl_data  = CWIDTH'(1);
        bus.ctrl_valid = 1'b1;
        bus.in1_data   = WIDTH'(5);
        bus.in1_valid  = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            cx = bus.ctrl_valid && bus.ctrl_ready;
            ix = bus.in1_valid && bus.in1_ready;
            @(negedge CLK);
            if (cx) bus.ctrl_valid = 1'b0;
            if (ix) bus.in1_valid = 1'b0;
            got = bus.out_valid;
        end
        check_eq("bp_reach_send", got, 1);
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_valid", bus.out_valid, 1);
            check_eq("bp_data", bus.out_data, 5);
            check_eq("bp_ctrl_ready", bus.ctrl_ready, 0);
            @(negedge CLK);
        end
        bus.out_ready = 1'b1;
        @(negedge CLK);
        check_eq("bp_one_xfer", bus.out_valid, 0);
        check_eq("bp_back_idle", bus.ctrl_ready, 1);
        bus.out_ready = 1'b0;
    endtask

    task automatic reset_mid_op();
        // Reset while waiting for data; the offered in2 token must not be taken on the reset edge.
        bus.ctrl_data  = CWIDTH'(2);
        bus.ctrl_valid = 1'b1;
        @(negedge CLK);
        bus.ctrl_valid = 1'b0;
        check_eq("rst_wait_in2_ready", bus.in2_ready, 1);
        _RESET = 1'b1;
        bus.in2_valid = 1'b1;
        bus.in2_data  = WIDTH'(3);
        @(negedge CLK);
        check_reset_vals("rst_wait");
        _RESET = 1'b0;
        bus.in2_valid = 1'b0;
        @(negedge CLK);
        check_eq("rst_wait_ctrl_ready", bus.ctrl_ready, 1);

        // Reset while holding a token in the output register.
        bus.out_ready  = 1'b0;
        bus.ctrl_data  = CWIDTH'(0);
        bus.ctrl_valid = 1'b1;
        bus.in0_valid  = 1'b1;
        bus.in0_data   = WIDTH'(9);
        @(negedge CLK);
        bus.ctrl_valid = 1'b0;
        @(negedge CLK);
        bus.in0_valid = 1'b0;
        check_eq("rst_send_valid", bus.out_valid, 1);
        check_eq("rst_send_data", bus.out_data, 9);
        _RESET = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge CLK);
        check_reset_vals("rst_send");
        _RESET = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge CLK);
        check_eq("rst_send_ctrl_ready", bus.ctrl_ready, 1);
    endtask

    initial begin
        idle_bus();
        bus.ctrl_data = '0;
        bus.in0_data  = '0;
        bus.in1_data  = '0;
        bus.in2_data  = '0;
        _RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_vals("por");
        _RESET = 1'b0;
        @(negedge CLK);
        check_eq("ctrl_ready_rise", bus.ctrl_ready, 1);

        ctrl_list = '{0, 1, 2};
        for (int k = 0; k < 3; k++) begin
            strm[k].delete();
            strm[k].push_back(WIDTH'(1));
        end
        run_seq("basic", 100, 100, 1'b1);

        ctrl_list = '{0, 0, 2, 1, 2};
        fill_inc(8);
        run_seq("order", 100, 100, 1'b1);

        ctrl_list = '{3, 0};
        strm[0] = '{WIDTH'(7)};
        strm[1] = '{WIDTH'(11)};
        strm[2] = '{WIDTH'(12)};
        run_seq("illegal", 100, 100, 1'b0);

        backpressure();

        ctrl_list.delete();
        for (int i = 0; i < 12; i++) ctrl_list.push_back(int'($urandom_range(2)));
        fill_inc(20);
        run_seq("rate", 100, 100, 1'b1);

        reset_mid_op();
        ctrl_list = '{0};
        strm[0] = '{WIDTH'(4)};
        strm[1] = '{WIDTH'(6)};
        strm[2] = '{WIDTH'(8)};
        run_seq("post_reset", 100, 100, 1'b1);

        for (int r = 0; r < 4; r++) begin
            ctrl_list.delete();
            for (int i = 0; i < 30; i++) ctrl_list.push_back(int'($urandom_range(3)));
            fill_rand(40);
            run_seq("rand", int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
